// File: rtl/mul_sched.sv
// Four-requester round-robin front end sharing one shift-add multiplier.
// Each grant runs exactly N add/shift steps, then shows the product for one cycle.
module mul_sched #(
    parameter int N = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [4*N-1:0]   a_in,
    input  logic [4*N-1:0]   b_in,
    output logic [3:0]       ack,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_id,
    output logic [2*N-1:0]   product
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [2*N-1:0] a_reg_q, a_reg_d;
    logic [N-1:0]   b_reg_q, b_reg_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     owner_q, owner_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [3:0]     ack_q, ack_d;
    logic           done_q, done_d;
    logic [2*N-1:0] product_q, product_d;

    logic           grant_any;
    logic [1:0]     win;
    logic [1:0]     idx;
    logic [2*N-1:0] addend;
    logic [2*N-1:0] sum;

    // Scan from ptr+3 down to ptr so the nearest requester wins last.
    always_comb begin
        grant_any = 1'b0;
        win       = ptr_q;
        idx       = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                grant_any = 1'b1;
                win       = idx;
            end
        end
    end

    assign addend = b_reg_q[0] ? a_reg_q : '0;
    assign sum    = acc_q + addend;

    always_comb begin
        state_d   = state_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        acc_d     = acc_q;
        count_d   = count_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    a_reg_d = {{N{1'b0}}, a_in[int'(win)*N +: N]};
                    b_reg_d = b_in[int'(win)*N +: N];
                    acc_d   = '0;
                    count_d = CW'(N);
                    owner_d = win;
                    ptr_d   = win + 2'd1;
                    ack_d   = 4'b0001 << win;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = sum;
                a_reg_d = a_reg_q << 1;
                b_reg_d = b_reg_q >> 1;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    product_d = sum;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign ack     = ack_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign done_id = owner_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched: a cycle model predicts grants, and a
// scoreboard of expected (id, product) pairs is checked at each done.
module tb_mul_sched;

    localparam int N = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [4*N-1:0]   a_in;
    logic [4*N-1:0]   b_in;
    logic [3:0]       ack;
    logic             busy;
    logic             done;
    logic [1:0]       done_id;
    logic [2*N-1:0]   product;

    mul_sched #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .product (product)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]     id;
        logic [2*N-1:0] p;
    } exp_t;

    int errors = 0;
    int checks = 0;
    int m_st = 0;
    int m_cnt = 0;
    int cyc_n = 0;
    int ack_cyc = 0;
    int last_done = 0;
    int prev_done = 0;
    logic [1:0]     m_ptr = '0;
    logic [2*N-1:0] m_prod = '0;
    exp_t sb[$];
    int   gq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*N +: N] = N'(a);
        b_in[i*N +: N] = N'(b);
    endtask

    task automatic cyc();
        logic [3:0] n_ack;
        logic       n_done;
        int         w;
        int         av;
        int         bv;
        exp_t       e;
        n_ack  = '0;
        n_done = 1'b0;
        case (m_st)
            0: begin
                if (req != 4'b0) begin
                    w = -1;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && req[(int'(m_ptr) + k) % 4])
                            w = (int'(m_ptr) + k) % 4;
                    av = int'(a_in[w*N +: N]);
                    bv = int'(b_in[w*N +: N]);
                    e.id = 2'(w);
                    e.p  = (2*N)'(av * bv);
                    sb.push_back(e);
                    n_ack = 4'(1 << w);
                    m_ptr = 2'(w + 1);
                    m_cnt = N;
                    m_st  = 1;
                end
            end
            1: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_st   = 2;
                    n_done = 1'b1;
                end
            end
            default: m_st = 0;
        endcase
        @(posedge clk);
        #1;
        cyc_n++;
        if (ack !== 4'b0 || n_ack !== 4'b0)
            chk("ack", 32'(ack), 32'(n_ack));
        chk("busy", 32'(busy), 32'(m_st != 0));
        if (done !== 1'b0 || n_done) begin
            chk("done", 32'(done), 32'(n_done));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", 32'(done_id), 32'(e.id));
                    chk("product", 32'(product), 32'(e.p));
                    chk("latency", 32'(cyc_n - ack_cyc), 32'(N));
                    m_prod    = e.p;
                    prev_done = last_done;
                    last_done = cyc_n;
                end
            end
        end else begin
            chk("product_hold", 32'(product), 32'(m_prod));
        end
        if (ack !== 4'b0) begin
            ack_cyc = cyc_n;
            for (int k = 0; k < 4; k++)
                if (ack[k] === 1'b1) gq.push_back(k);
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        m_st   = 0;
        m_cnt  = 0;
        m_ptr  = '0;
        m_prod = '0;
        sb.delete();
        gq.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        @(posedge clk);
        #1;
        do_reset();

        // 31 * 31 on requester 2
        set_op(2, 31, 31);
        req = 4'b0100;
        cyc();
        req = '0;
        repeat (7) cyc();
        chk("p961", 32'(product), 32'd961);

        // all four requesting after reset: order 0,1,2,3, 7 cycles apart
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, i + 1, i + 2);
        req = 4'b1111;
        repeat (28) cyc();
        req = '0;
        repeat (3) cyc();
        chk("rr4_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk("rr4_order", 32'(gq[i]), 32'(i));
        chk("spacing", 32'(last_done - prev_done), 32'd7);
        chk("sb_drain1", 32'(sb.size()), 32'd0);

        // requesters 0 and 3 held: must alternate
        gq.delete();
        set_op(0, 5, 6);
        set_op(3, 7, 3);
        req = 4'b1001;
        repeat (28) cyc();
        req = '0;
        repeat (3) cyc();
        chk("alt_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk("alt_order", 32'(gq[i]), (i % 2 == 0) ? 32'd0 : 32'd3);

        // reset in the third RUN cycle of 13*7
        set_op(0, 13, 7);
        req = 4'b0001;
        cyc();
        req = '0;
        cyc();
        cyc();
        do_reset();
        repeat (8) cyc();
        set_op(1, 3, 4);
        req = 4'b0010;
        cyc();
        req = '0;
        repeat (7) cyc();
        chk("p12", 32'(product), 32'd12);
        chk("id1", 32'(done_id), 32'd1);

        // zero operand still takes full latency
        set_op(1, 0, 17);
        req = 4'b0010;
        cyc();
        req = '0;
        repeat (7) cyc();
        chk("p0", 32'(product), 32'd0);

        // req[1] pulsed during RUN must be ignored and leave ptr alone
        gq.delete();
        set_op(0, 6, 6);
        req = 4'b0001;
        cyc();
        req = '0;
        cyc();
        req = 4'b0010;
        cyc();
        cyc();
        req = '0;
        repeat (5) cyc();
        chk("pulse_grants", 32'(gq.size()), 32'd1);
        set_op(0, 3, 3);
        set_op(1, 2, 9);
        req = 4'b0011;
        cyc();
        req = '0;
        repeat (7) cyc();
        chk("ptr_kept_n", 32'(gq.size()), 32'd2);
        if (gq.size() >= 2)
            chk("ptr_kept", 32'(gq[1]), 32'd1);
        chk("sb_drain2", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
